// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port data memory between two requesters: A (fetch side)
// and B (load/store side). Each requester uses a req/ack handshake; every
// granted transaction performs exactly one memory access and finishes with a
// one-cycle ack pulse. Arbitration is round-robin. When both sides request
// in the same IDLE cycle, the side that was not served last wins.
//
// Transaction timing (one transaction every 3 cycles at full load):
//   IDLE   : a pending request is granted. Owner, we, addr and wdata are
//            latched at the clock edge.
//   ACCESS : the memory is driven from the latched fields. A write commits at
//            the edge ending ACCESS. For a read, mem_rdata is captured into
//            rdata at that edge.
//   RESP   : the owner's ack is high for this cycle and rdata holds the
//            captured value. Priority passes to the other requester.
//
// Every output comes straight from a flip-flop. The asynchronous reset
// therefore drops mem_write and the acks at once. A write that is cut off by
// reset during ACCESS never reaches the memory.
//
// Ports
//   clock                          single clock, rising edge
//   reset_n                        asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata      requester A request, direction, address, data
//   a_ack                          requester A completion pulse
//   b_req/b_we/b_addr/b_wdata      requester B, same meaning as A
//   b_ack                          requester B completion pulse
//   rdata                          read data of the acked transaction
//   busy                           high in ACCESS and RESP
//   mem_write/mem_read             memory strobes, high only in ACCESS
//   mem_addr/mem_wdata             memory address and write data
//   mem_rdata                      memory read data (combinational while mem_read)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Requester identifiers, used for owner and priority.
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                prio_q, prio_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic                busy_q, busy_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;

  logic                grant_any_s;
  logic                grant_side_s;
  logic                grant_we_s;
  logic [ADDR_W-1:0]   grant_addr_s;
  logic [DATA_W-1:0]   grant_wdata_s;

  // Round-robin selection among the current requests. B wins only if it
  // requests and either A is idle or B holds the priority. The selected
  // side's fields are steered to the capture registers.
  always_comb begin
    grant_any_s  = a_req | b_req;
    grant_side_s = b_req & (~a_req | (prio_q == SIDE_B));
    if (grant_side_s == SIDE_B) begin
      grant_we_s    = b_we;
      grant_addr_s  = b_addr;
      grant_wdata_s = b_wdata;
    end else begin
      grant_we_s    = a_we;
      grant_addr_s  = a_addr;
      grant_wdata_s = a_wdata;
    end
  end

  // Next-state and next-output decode. The output registers are loaded one
  // state early so that they are valid during the cycle they belong to.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    busy_d      = 1'b0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_d     = ST_ACCESS;
          owner_d     = grant_side_s;
          we_d        = grant_we_s;
          addr_d      = grant_addr_s;
          wdata_d     = grant_wdata_s;
          busy_d      = 1'b1;
          mem_write_d = grant_we_s;
          mem_read_d  = ~grant_we_s;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        state_d = ST_RESP;
        busy_d  = 1'b1;
        a_ack_d = (owner_q == SIDE_A);
        b_ack_d = (owner_q == SIDE_B);
        // Reads capture the memory word. Writes leave the previous rdata.
        if (!we_q) begin
          rdata_d = mem_rdata;
        end else begin
          rdata_d = rdata_q;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        prio_d  = ~owner_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched transaction fields and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= SIDE_A;
      prio_q      <= SIDE_A;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      busy_q      <= busy_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  // The latched fields stay stable across ACCESS. Outside ACCESS the
  // strobes are low, so the memory ignores these values.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Randomized two-requester traffic against mem_port_arbiter driving a
// behavioural memory. The reference is transaction level:
//   - A grant is taken whenever the arbiter is free and a request is present.
//   - Both requesting selects the side not served last (A after reset).
//   - The access happens one cycle after the grant.
//   - The ack is seen two cycles after the grant.
//   - The arbiter is free again three cycles after the grant.
// A reference array holds the expected memory image.
// Resets are injected during ACCESS and RESP. Each requester then reissues
// its outstanding request.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic       clock;
  logic       reset_n;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_ack, b_ack, busy, mem_write, mem_read;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Requester drive state, index 0 = A, 1 = B.
  logic       req_v   [2];
  logic       we_v    [2];
  logic [7:0] addr_v  [2];
  logic [7:0] wdata_v [2];
  logic       out_v   [2];
  logic       pulse_v [2];
  logic       grant_v [2];
  logic       ack_seen[2];
  int         gap_v   [2];

  assign a_req   = req_v[0];
  assign a_we    = we_v[0];
  assign a_addr  = addr_v[0];
  assign a_wdata = wdata_v[0];
  assign b_req   = req_v[1];
  assign b_we    = we_v[1];
  assign b_addr  = addr_v[1];
  assign b_wdata = wdata_v[1];

  // Behavioural memory: synchronous write, combinational read while mem_read.
  logic [7:0] sim_mem [256];
  logic       preload_done;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 29 + 7) & 255);
  endfunction

  always @(posedge clock) begin
    if (!preload_done) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= init_val(i);
    end else if (mem_write) begin
      sim_mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ? sim_mem[mem_addr] : 8'h00;

  // Reference model state.
  logic [7:0] ref_mem [256];
  int         cd;          // cycles until the arbiter is free again
  logic       prio;        // side that wins a tie, 0 = A
  logic       m_own;
  logic       m_we;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] exp_rd;

  int n_cmp;
  int n_err;
  int n_rst;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic rand_fields(input int s);
    we_v[s]    = 1'($urandom_range(0, 1));
    addr_v[s]  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
    wdata_v[s] = 8'($urandom);
  endtask

  task automatic new_txn(input int s);
    out_v[s]   = 1'b1;
    grant_v[s] = 1'b0;
    req_v[s]   = 1'b1;
    pulse_v[s] = ($urandom_range(0, 3) == 0);
    rand_fields(s);
  endtask

  // Requester behaviour: drop or renew req where ack is sampled, optional
  // idle gap, and optional early drop of req once the grant has happened.
  task automatic drive_side(input int s);
    if (ack_seen[s]) begin
      out_v[s]   = 1'b0;
      grant_v[s] = 1'b0;
      gap_v[s]   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
    end
    if (!out_v[s]) begin
      if (gap_v[s] == 0) begin
        new_txn(s);
      end else begin
        gap_v[s]--;
        req_v[s] = 1'b0;
        rand_fields(s);
      end
    end else if (grant_v[s] && pulse_v[s]) begin
      req_v[s] = 1'b0;
      rand_fields(s);
    end
  endtask

  // Advance the reference by one cycle, then compare with the DUT outputs.
  task automatic model_step();
    if (cd > 0) cd--;
    if (cd == 1) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      exp_rd = ref_mem[m_addr];
    end
    check_val("busy", busy, cd != 0);
    check_val("a_ack", a_ack, (cd == 1) && (m_own == 1'b0));
    check_val("b_ack", b_ack, (cd == 1) && (m_own == 1'b1));
    check_val("mem_write", mem_write, (cd == 2) && m_we);
    check_val("mem_read", mem_read, (cd == 2) && !m_we);
    if (cd == 2) begin
      check_val("mem_addr", mem_addr, m_addr);
      if (m_we) check_val("mem_wdata", mem_wdata, m_wdata);
    end
    if (cd == 1 && !m_we) check_val("rdata", rdata, exp_rd);
    ack_seen[0] = a_ack;
    ack_seen[1] = b_ack;
  endtask

  // Grant decision for the coming edge, based on the requests just driven.
  task automatic model_grant();
    if (cd == 0 && (req_v[0] || req_v[1])) begin
      if (req_v[0] && req_v[1]) m_own = prio;
      else                      m_own = req_v[1];
      m_we    = we_v[m_own];
      m_addr  = addr_v[m_own];
      m_wdata = wdata_v[m_own];
      cd      = 3;
      prio    = ~m_own;
      grant_v[m_own] = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_a_ack"}, a_ack, 0);
    check_val({tag, "_b_ack"}, b_ack, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_mem_write"}, mem_write, 0);
    check_val({tag, "_mem_read"}, mem_read, 0);
    check_val({tag, "_rdata"}, rdata, 0);
  endtask

  // Asynchronous reset in the middle of a cycle, held across one edge.
  task automatic apply_reset();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    n_rst++;
    cd   = 0;
    prio = 1'b0;
    for (int s = 0; s < 2; s++) begin
      ack_seen[s] = 1'b0;
      if (out_v[s]) new_txn(s);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_rst = 0;
    cd = 0; prio = 1'b0; m_own = 1'b0; m_we = 1'b0;
    m_addr = 8'h00; m_wdata = 8'h00; exp_rd = 8'h00;
    preload_done = 1'b0;
    reset_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = 8'h00; wdata_v[s] = 8'h00;
      out_v[s] = 1'b0; pulse_v[s] = 1'b0; grant_v[s] = 1'b0;
      ack_seen[s] = 1'b0; gap_v[s] = 0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    repeat (2) @(negedge clock);
    preload_done = 1'b1;
    @(negedge clock);
    check_reset_outputs("reset");
    check_val("reset_mem_addr", mem_addr, 0);
    check_val("reset_mem_wdata", mem_wdata, 0);
    reset_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      model_step();
      if (cyc > 20 && cd != 0 && $urandom_range(0, 29) == 0) apply_reset();
      drive_side(0);
      drive_side(1);
      model_grant();
    end

    // Let any transaction in flight finish.
    for (int s = 0; s < 2; s++) begin
      req_v[s] = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      model_step();
    end
    check_val("idle_busy", busy, 0);
    for (int i = 0; i < 256; i++) check_val("mem_image", sim_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
